// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared NoC constants and types used by the link arbiter and by the router
// crossbar: flit geometry, tail-field encoding, downstream buffer depth,
// credit counter width and the wormhole lock state type.
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W   = 20;
    localparam int TAIL_BIT = 19;
    localparam int DEPTH    = 7;
    localparam int CW       = 3;
    localparam int GIDW     = 3;

    // Value of the tail field that marks the last flit of a packet
    localparam logic TAIL_FLIT = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// circularly starting one position after i_base and returns the first
// requester found.
// Ports:
//   i_req    N-bit request vector
//   i_base   index of the previous winner (search starts at i_base+1 mod N)
//   o_grant  one-hot grant (all zero when nothing is requested)
//   o_idx    encoded winner index (equals i_base when nothing is requested)
//   o_any    at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_base,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [SW-1:0] w_pos;

    // Offset k = N wraps back to i_base itself, so a requester that is the
    // only one asking (e.g. a locked owner) is still found.
    always_comb begin
        o_grant = '0;
        o_idx   = i_base;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = SW'((int'(i_base) + k) % N);
            if (!o_any && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = IW'(w_pos);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_link_credit_arbiter.sv
// ---------------------------------------------------------------------------
// noc_link_credit_arbiter
// Shares one NoC output link between N local requesters using round-robin
// arbitration with a wormhole lock (the grant is held until the owner's tail
// flit goes out) and credit-based flow control toward the downstream buffer.
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   i_req_data    flit of requester i at [i*FLIT_W +: FLIT_W]
//   i_req_valid   requester i holds a valid flit
//   o_req_ready   one-hot pop strobe, asserted on send cycles only
//   o_link_data   registered flit to the downstream link
//   o_link_valid  link data valid, one cycle per flit
//   i_ci          credit return pulse from downstream
//   o_credits     current credit count
//   o_grant_id    index of the last/current granted requester
//   o_locked      packet in flight, grant held
//   o_credit_err  sticky credit overflow flag
// ---------------------------------------------------------------------------
module noc_link_credit_arbiter #(
    parameter int N        = 4,
    parameter int FLIT_W   = noc_pkg::FLIT_W,
    parameter int DEPTH    = noc_pkg::DEPTH,
    parameter int CW       = noc_pkg::CW,
    parameter int TAIL_BIT = noc_pkg::TAIL_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*FLIT_W-1:0]   i_req_data,
    input  logic [N-1:0]          i_req_valid,
    output logic [N-1:0]          o_req_ready,
    output logic [FLIT_W-1:0]     o_link_data,
    output logic                  o_link_valid,
    input  logic                  i_ci,
    output logic [CW-1:0]         o_credits,
    output logic [2:0]            o_grant_id,
    output logic                  o_locked,
    output logic                  o_credit_err
);

    import noc_pkg::*;

    lock_state_e          r_state;
    logic [CW-1:0]        r_credits;
    logic [GIDW-1:0]      r_grantId;
    logic [FLIT_W-1:0]    r_linkData;
    logic                 r_linkValid;
    logic                 r_creditErr;

    logic [N-1:0]         w_lockMask;
    logic [N-1:0]         w_eligible;
    logic [N-1:0]         w_grant;
    logic [GIDW-1:0]      w_winIdx;
    logic                 w_any;
    logic                 w_send;
    logic [FLIT_W-1:0]    w_selFlit;
    logic                 w_tail;

    // While locked only the owner may win; the arbiter's wrap-around search
    // reaches the owner itself, so no separate path is needed.
    assign w_lockMask = N'(1) << r_grantId;
    assign w_eligible = (r_state == ST_LOCKED) ? (i_req_valid & w_lockMask) : i_req_valid;

    rr_arbiter #(
        .N  (N),
        .IW (GIDW)
    ) u_rrArbiter (
        .i_req   (w_eligible),
        .i_base  (r_grantId),
        .o_grant (w_grant),
        .o_idx   (w_winIdx),
        .o_any   (w_any)
    );

    // Reset gates the pop strobe so upstream sees no pop while rst is held.
    assign w_send      = rst && (r_credits != '0) && w_any;
    assign o_req_ready = w_send ? w_grant : '0;
    assign w_selFlit   = i_req_data[int'(w_winIdx)*FLIT_W +: FLIT_W];
    assign w_tail      = (w_selFlit[TAIL_BIT] == TAIL_FLIT);

    // Output register, round-robin pointer and wormhole lock FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_grantId   <= GIDW'(N - 1);
            r_linkData  <= '0;
            r_linkValid <= 1'b0;
        end else if (w_send) begin
            r_linkData  <= w_selFlit;
            r_linkValid <= 1'b1;
            r_grantId   <= w_winIdx;
            r_state     <= w_tail ? ST_IDLE : ST_LOCKED;
        end else begin
            r_linkValid <= 1'b0;
        end
    end

    // Credit counter: a send consumes one slot, ci returns one. A return
    // arriving at full credit is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credits   <= CW'(DEPTH);
            r_creditErr <= 1'b0;
        end else begin
            case ({w_send, i_ci})
                2'b10: r_credits <= r_credits - CW'(1);
                2'b01: begin
                    if (r_credits == CW'(DEPTH)) begin
                        r_creditErr <= 1'b1;
                    end else begin
                        r_credits <= r_credits + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_link_data  = r_linkData;
    assign o_link_valid = r_linkValid;
    assign o_credits    = r_credits;
    assign o_grant_id   = r_grantId;
    assign o_locked     = (r_state == ST_LOCKED);
    assign o_credit_err = r_creditErr;

endmodule

// File: tb/tb_noc_link_credit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_link_credit_arbiter
// Directed scenarios for reset, round-robin drain, credit return, wormhole
// lock, credit overflow, asynchronous reset and single requester, followed by
// a randomized run checked against a behavioural model of the link.
// ---------------------------------------------------------------------------
module tb_noc_link_credit_arbiter;

    localparam int N  = 4;
    localparam int FW = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*FW-1:0]   reqData = '0;
    logic [N-1:0]      reqValid = '0;
    logic [N-1:0]      reqReady;
    logic [FW-1:0]     linkData;
    logic              linkValid;
    logic              ci = 1'b0;
    logic [2:0]        credits;
    logic [2:0]        grantId;
    logic              locked;
    logic              creditErr;

    int passCount  = 0;
    int checkCount = 0;

    noc_link_credit_arbiter #(
        .N        (N),
        .FLIT_W   (FW),
        .DEPTH    (7),
        .CW       (3),
        .TAIL_BIT (19)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_data   (reqData),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .o_link_data  (linkData),
        .o_link_valid (linkValid),
        .i_ci         (ci),
        .o_credits    (credits),
        .o_grant_id   (grantId),
        .o_locked     (locked),
        .o_credit_err (creditErr)
    );

    always #5 clk = ~clk;

    // Drive inputs on the falling edge and let combinational outputs settle
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*FW-1:0] d, input logic c);
        @(negedge clk);
        reqValid = v;
        reqData  = d;
        ci       = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every requester holds a tail flit tagged with its index and a cycle tag
    function automatic logic [N*FW-1:0] allTail(input int tag);
        logic [N*FW-1:0] d;
        for (int i = 0; i < N; i++) begin
            d[i*FW +: FW] = 20'h80000 | 20'(i << 8) | 20'(tag & 8'hFF);
        end
        return d;
    endfunction

    task automatic test_reset();
        rst      = 1'b0;
        reqValid = '0;
        ci       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({credits, linkValid, linkData, reqReady, grantId, locked, creditErr} !==
            {3'd7, 1'b0, 20'h0, 4'b0000, 3'd3, 1'b0, 1'b0})
            $display("[TB] FAIL reset_state: got cr=%0d lv=%b ld=%h rr=%b gid=%0d lk=%b err=%b, want cr=7 lv=0 ld=0 rr=0000 gid=3 lk=0 err=0",
                     credits, linkValid, linkData, reqReady, grantId, locked, creditErr);
        else passCount++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_rr_drain();
        logic [N*FW-1:0] d;
        logic [N-1:0]    expReady;
        for (int c = 0; c < 7; c++) begin
            d        = allTail(c);
            expReady = N'(1 << (c % N));
            applyStimulus(4'hF, d, 1'b0);
            checkCount++;
            if (reqReady !== expReady)
                $display("[TB] FAIL rr_ready c=%0d: got %b want %b", c, reqReady, expReady);
            else passCount++;
            tick();
            checkCount++;
            if ({linkValid, grantId, credits, linkData} !==
                {1'b1, 3'(c % N), 3'(6 - c), d[(c % N)*FW +: FW]})
                $display("[TB] FAIL rr_link c=%0d: got lv=%b gid=%0d cr=%0d ld=%h want lv=1 gid=%0d cr=%0d ld=%h",
                         c, linkValid, grantId, credits, linkData, c % N, 6 - c, d[(c % N)*FW +: FW]);
            else passCount++;
        end
        applyStimulus(4'hF, allTail(7), 1'b0);
        checkCount++;
        if (reqReady !== 4'b0000)
            $display("[TB] FAIL rr_no_credit_ready: got %b want 0000", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({linkValid, credits} !== {1'b0, 3'd0})
            $display("[TB] FAIL rr_no_credit_link: got lv=%b cr=%0d want lv=0 cr=0", linkValid, credits);
        else passCount++;
    endtask

    task automatic test_credit_return();
        applyStimulus(4'hF, allTail(8), 1'b1);
        checkCount++;
        if (reqReady !== 4'b0000)
            $display("[TB] FAIL ci_same_cycle_ready: got %b want 0000", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({credits, linkValid} !== {3'd1, 1'b0})
            $display("[TB] FAIL ci_credit_up: got cr=%0d lv=%b want cr=1 lv=0", credits, linkValid);
        else passCount++;
        applyStimulus(4'hF, allTail(9), 1'b0);
        checkCount++;
        if (reqReady !== 4'b1000)
            $display("[TB] FAIL ci_rr_continue: got %b want 1000", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({credits, grantId, linkValid} !== {3'd0, 3'd3, 1'b1})
            $display("[TB] FAIL ci_one_send: got cr=%0d gid=%0d lv=%b want cr=0 gid=3 lv=1", credits, grantId, linkValid);
        else passCount++;
        applyStimulus(4'hF, allTail(10), 1'b0);
        checkCount++;
        if (reqReady !== 4'b0000)
            $display("[TB] FAIL ci_exhausted_again: got %b want 0000", reqReady);
        else passCount++;
        tick();
    endtask

    task automatic test_lock();
        logic [N*FW-1:0] d;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0000, '0, 1'b1);
            tick();
        end
        checkCount++;
        if (credits !== 3'd7)
            $display("[TB] FAIL lock_refill: got cr=%0d want 7", credits);
        else passCount++;

        d = allTail(11);
        d[1*FW +: FW] = 20'h01111;
        applyStimulus(4'b0010, d, 1'b0);
        checkCount++;
        if (reqReady !== 4'b0010)
            $display("[TB] FAIL lock_head_ready: got %b want 0010", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({locked, grantId} !== {1'b1, 3'd1})
            $display("[TB] FAIL lock_head_state: got lk=%b gid=%0d want lk=1 gid=1", locked, grantId);
        else passCount++;

        for (int b = 0; b < 2; b++) begin
            d[1*FW +: FW] = 20'h02220 | 20'(b);
            applyStimulus(4'b0111, d, 1'b0);
            checkCount++;
            if (reqReady !== 4'b0010)
                $display("[TB] FAIL lock_body_ready b=%0d: got %b want 0010", b, reqReady);
            else passCount++;
            tick();
            checkCount++;
            if ({locked, linkData} !== {1'b1, 20'h02220 | 20'(b)})
                $display("[TB] FAIL lock_body_link b=%0d: got lk=%b ld=%h want lk=1 ld=%h", b, locked, linkData, 20'h02220 | 20'(b));
            else passCount++;
        end

        for (int s = 0; s < 2; s++) begin
            applyStimulus(4'b0101, d, 1'b0);
            checkCount++;
            if (reqReady !== 4'b0000)
                $display("[TB] FAIL lock_stall_ready s=%0d: got %b want 0000", s, reqReady);
            else passCount++;
            tick();
            checkCount++;
            if ({linkValid, locked} !== {1'b0, 1'b1})
                $display("[TB] FAIL lock_stall_state s=%0d: got lv=%b lk=%b want lv=0 lk=1", s, linkValid, locked);
            else passCount++;
        end

        d[1*FW +: FW] = 20'h8111F;
        applyStimulus(4'b0111, d, 1'b0);
        checkCount++;
        if (reqReady !== 4'b0010)
            $display("[TB] FAIL lock_tail_ready: got %b want 0010", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({locked, linkData} !== {1'b0, 20'h8111F})
            $display("[TB] FAIL lock_tail_state: got lk=%b ld=%h want lk=0 ld=8111f", locked, linkData);
        else passCount++;

        applyStimulus(4'b0101, d, 1'b0);
        checkCount++;
        if (reqReady !== 4'b0100)
            $display("[TB] FAIL lock_release_next: got %b want 0100", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({grantId, credits} !== {3'd2, 3'd2})
            $display("[TB] FAIL lock_release_state: got gid=%0d cr=%0d want gid=2 cr=2", grantId, credits);
        else passCount++;
    endtask

    task automatic test_credit_ovf();
        applyStimulus(4'b0000, '0, 1'b1);
        tick();
        applyStimulus(4'b0001, allTail(12), 1'b1);
        checkCount++;
        if (reqReady !== 4'b0001)
            $display("[TB] FAIL ovf_send_ready: got %b want 0001", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if (credits !== 3'd3)
            $display("[TB] FAIL ovf_send_and_ci: got cr=%0d want 3", credits);
        else passCount++;
        repeat (4) begin
            applyStimulus(4'b0000, '0, 1'b1);
            tick();
        end
        checkCount++;
        if ({credits, creditErr} !== {3'd7, 1'b0})
            $display("[TB] FAIL ovf_full: got cr=%0d err=%b want cr=7 err=0", credits, creditErr);
        else passCount++;
        applyStimulus(4'b0000, '0, 1'b1);
        tick();
        checkCount++;
        if ({credits, creditErr} !== {3'd7, 1'b1})
            $display("[TB] FAIL ovf_flag: got cr=%0d err=%b want cr=7 err=1", credits, creditErr);
        else passCount++;
        applyStimulus(4'b0000, '0, 1'b0);
        tick();
        checkCount++;
        if (creditErr !== 1'b1)
            $display("[TB] FAIL ovf_sticky: got err=%b want 1", creditErr);
        else passCount++;
    endtask

    task automatic test_async_reset();
        logic [N*FW-1:0] d;
        d = allTail(13);
        d[0 +: FW] = 20'h00ABC;
        applyStimulus(4'b0001, d, 1'b0);
        tick();
        checkCount++;
        if ({locked, linkValid} !== {1'b1, 1'b1})
            $display("[TB] FAIL arst_head: got lk=%b lv=%b want lk=1 lv=1", locked, linkValid);
        else passCount++;
        d[0 +: FW] = 20'h00ABD;
        applyStimulus(4'b0001, d, 1'b0);
        checkCount++;
        if (reqReady !== 4'b0001)
            $display("[TB] FAIL arst_body_ready: got %b want 0001", reqReady);
        else passCount++;
        #2;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({reqReady, linkValid, locked, credits, grantId, creditErr} !==
            {4'b0000, 1'b0, 1'b0, 3'd7, 3'd3, 1'b0})
            $display("[TB] FAIL arst_immediate: got rr=%b lv=%b lk=%b cr=%0d gid=%0d err=%b want rr=0000 lv=0 lk=0 cr=7 gid=3 err=0",
                     reqReady, linkValid, locked, credits, grantId, creditErr);
        else passCount++;
        reqValid = '0;
        @(negedge clk);
        rst      = 1'b1;
        reqValid = 4'hF;
        reqData  = allTail(14);
        #1;
        checkCount++;
        if (reqReady !== 4'b0001)
            $display("[TB] FAIL arst_first_grant: got %b want 0001", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({grantId, linkValid} !== {3'd0, 1'b1})
            $display("[TB] FAIL arst_first_link: got gid=%0d lv=%b want gid=0 lv=1", grantId, linkValid);
        else passCount++;
    endtask

    task automatic test_single();
        logic [N*FW-1:0] d;
        d = allTail(15);
        d[2*FW +: FW] = 20'h8ABCD;
        applyStimulus(4'b0100, d, 1'b0);
        checkCount++;
        if (reqReady !== 4'b0100)
            $display("[TB] FAIL single_ready: got %b want 0100", reqReady);
        else passCount++;
        tick();
        checkCount++;
        if ({linkData, linkValid, grantId} !== {20'h8ABCD, 1'b1, 3'd2})
            $display("[TB] FAIL single_link: got ld=%h lv=%b gid=%0d want ld=8abcd lv=1 gid=2", linkData, linkValid, grantId);
        else passCount++;
    endtask

    // Behavioural model: the link owner, the credit pool and the last winner
    // are tracked as plain integers and recomputed from the arbitration rules.
    task automatic test_random();
        int              mCredits;
        int              mLast;
        bit              mLocked;
        bit              mErr;
        logic [FW-1:0]   mData;
        logic [N-1:0]    v;
        logic [N*FW-1:0] d;
        logic            c;
        logic [FW-1:0]   f;
        logic [N-1:0]    expReady;
        int              w;
        int              newC;

        @(negedge clk);
        reqValid = '0;
        ci       = 1'b0;
        rst      = 1'b0;
        #2;
        rst      = 1'b1;
        mCredits = 7;
        mLast    = N - 1;
        mLocked  = 1'b0;
        mErr     = 1'b0;
        mData    = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            v = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                f     = FW'($urandom);
                f[19] = ($urandom_range(0, 2) == 0);
                d[i*FW +: FW] = f;
            end
            c = ($urandom_range(0, 2) == 0);
            applyStimulus(v, d, c);

            w = -1;
            if (mCredits > 0) begin
                if (mLocked) begin
                    if (v[mLast]) w = mLast;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (w < 0 && v[(mLast + k) % N]) w = (mLast + k) % N;
                    end
                end
            end
            expReady = (w >= 0) ? N'(1 << w) : '0;
            checkCount++;
            if (reqReady !== expReady)
                $display("[TB] FAIL rand_ready cyc=%0d: got %b want %b", cyc, reqReady, expReady);
            else passCount++;

            tick();
            if (w >= 0) begin
                mData   = d[w*FW +: FW];
                mLast   = w;
                mLocked = !mData[19];
            end
            newC = mCredits - ((w >= 0) ? 1 : 0) + (c ? 1 : 0);
            if (newC > 7) begin
                newC = 7;
                mErr = 1'b1;
            end
            mCredits = newC;

            checkCount++;
            if ({linkValid, linkData, credits, grantId, locked, creditErr} !==
                {(w >= 0), mData, 3'(mCredits), 3'(mLast), mLocked, mErr})
                $display("[TB] FAIL rand_state cyc=%0d: got lv=%b ld=%h cr=%0d gid=%0d lk=%b err=%b want lv=%b ld=%h cr=%0d gid=%0d lk=%b err=%b",
                         cyc, linkValid, linkData, credits, grantId, locked, creditErr,
                         (w >= 0), mData, mCredits, mLast, mLocked, mErr);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_rr_drain();
        test_credit_return();
        test_lock();
        test_credit_ovf();
        test_async_reset();
        test_single();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/noc_link_credit_arbiter.md
Name: noc_link_credit_arbiter

Overview:
- Shares one 20-bit NoC output link between N local requesters, e.g. PE output buffers or router input ports.
- Round-robin arbitration with wormhole packet lock: a grant is held until the requester's tail flit is sent.
- Tracks downstream buffer space with a credit counter; each credit is returned on `ci`.
- Sits between the PE/router output buffers and the downstream router input buffer.

Parameters:
- N, 4, number of requesters (2..8).
- FLIT_W, 20, flit width.
- DEPTH, 7, downstream buffer depth, which is also the initial credit count.
- CW, 3, credit counter width (must hold DEPTH).
- TAIL_BIT, 19, flit bit index marking the tail flit (1 = tail; single-flit packets set it).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_data  in  N*FLIT_W  flit of requester i at bits [i*FLIT_W +: FLIT_W].
- req_valid  in  N  requester i holds a valid flit.
- req_ready  out  N  one-hot pop strobe; the flit of requester i is consumed this cycle.
- link_data  out  FLIT_W  registered flit to the downstream link.
- link_valid  out  1  link_data valid, one cycle per flit.
- ci  in  1  credit return from downstream; one pulse = one freed slot.
- credits  out  CW  current credit count.
- grant_id  out  3  index of the last/current granted requester.
- locked  out  1  a packet is in flight and the grant is held.
- credit_err  out  1  sticky flag: credit overflow (ci received while credits == DEPTH).

Behaviour:
- Reset (async, rst = 0):
  - credits = DEPTH.
  - link_valid = 0, link_data = 0.
  - req_ready = 0.
  - grant_id = N-1, so requester 0 has first priority.
  - locked = 0, credit_err = 0.
- Send condition: send = (credits != 0) && a winner exists.
  - `ci` in the same cycle does not enable a send when credits == 0 (conservative).
- Winner, IDLE state (locked = 0):
  - First i with req_valid[i] = 1, searched circularly from grant_id+1 mod N.
- Winner, LOCKED state:
  - Only requester grant_id is eligible.
  - If it is not valid, or credits == 0, nothing is sent and the lock persists. Other requesters are never served mid-packet.
- req_ready: combinational, one-hot, asserted on a send cycle only.
- Registered updates on each send:
  - link_data <= selected flit.
  - link_valid <= 1.
  - grant_id <= winner.
- Latency: one cycle from the req_ready pulse to link_valid.
- On cycles without a send: link_valid <= 0; link_data holds its value.
- State transitions:
  - IDLE -> LOCKED when the sent flit has bit[TAIL_BIT] = 0.
  - LOCKED -> IDLE when the sent flit has bit[TAIL_BIT] = 1.
  - A tail flit sent from IDLE stays in IDLE.
- Credit update:
  - credits_next = credits - send + ci.
  - Simultaneous send and ci leaves credits unchanged.
  - ci while credits == DEPTH and no send: credits stays DEPTH and credit_err <= 1. credit_err clears only on reset.
  - Credits never underflow, because send requires credits != 0.
- Round-robin pointer: advances only on a send; it is unchanged while idle or stalled.
- Reset mid-packet: all state returns to reset values immediately. Any partially sent packet is abandoned; upstream/downstream recovery is outside this block.
- Invalid requesters are never granted, and nothing is granted when req_valid = 0.

Decomposition:
- Shared package `noc_pkg`: FLIT_W, TAIL_BIT, DEPTH, CW, and the flit tail-field constant.
- One sub-module, `rr_arbiter`:
  - Inputs: N-bit request, base pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational, reusable by the router crossbar.
- The lock FSM, credit counter and output register stay in the top block.

Test Plan:
- Reset, then req_valid = 4'b1111, all flits tail, ci = 0 → grants in order 0, 1, 2, 3, 0, 1, 2; credits falls 7 → 0. Eighth cycle: no req_ready, link_valid = 0.
- Credits = 0 with all requesters valid, then a one-cycle ci → exactly one flit sent the cycle after ci is sampled; credits returns to 0; RR order continues where it left off.
- Requester 1 sends head (bit19 = 0), then body flits, while req 0/2 stay valid → locked = 1 and only req 1 is served. Req 1 drops valid for 2 cycles: no sends, lock held. Tail sent → locked = 0 and requester 2 is granted next.
- Send and ci in the same cycle at credits = 3 → credits stays 3. ci at credits = 7 with no send → credits = 7 and credit_err = 1 (sticky).
- Assert rst = 0 asynchronously mid-packet → link_valid, locked, req_ready drop at once; credits = 7, grant_id = 3. After release, requester 0 is granted first.
- Single requester 2 valid with data 20'h8ABCD → req_ready = 4'b0100; next cycle link_data = 20'h8ABCD, link_valid = 1, grant_id = 2.
